// File: rtl/router_src_arbiter.sv
// Packet-level round-robin arbiter that shares one router_top input among NUM_SRC sources.
// Illegal-address packets are drained without reaching the router; length violations are flagged.
module router_src_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [NUM_SRC-1:0]   src_pkt_valid,
    input  logic [8*NUM_SRC-1:0] src_data,
    output logic [NUM_SRC-1:0]   src_busy,
    input  logic                 router_busy,
    output logic                 rtr_pkt_valid,
    output logic [7:0]           rtr_data,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 pkt_done,
    output logic                 len_err,
    output logic                 addr_err,
    output logic [1:0]           state_dbg
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [5:0]    len_q, len_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          pkt_done_q, pkt_done_d;
    logic          len_err_q, len_err_d;
    logic          addr_err_q, addr_err_d;

    logic [7:0]    own_data;
    logic          own_valid;
    logic [7:0]    win_hdr;
    logic [PW:0]   cand;
    logic          win_found;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] ptr_nxt;
    logic          last_slot;
    logic          byte_take;

    // Cyclic search for the first requester at or after the round-robin pointer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NUM_SRC)) begin
                cand = cand - (PW+1)'(NUM_SRC);
            end
            if (!win_found && src_pkt_valid[cand[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
    end

    assign ptr_nxt = (win_idx == PW'(NUM_SRC - 1)) ? '0 : win_idx + PW'(1);

    always_comb begin
        own_data  = 8'd0;
        own_valid = 1'b0;
        win_hdr   = 8'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (owner_q == PW'(i)) begin
                own_data  = src_data[8*i +: 8];
                own_valid = src_pkt_valid[i];
            end
            if (win_idx == PW'(i)) begin
                win_hdr = src_data[8*i +: 8];
            end
        end
    end

    // cnt==0 is always the header, so the parity slot only exists once a byte has moved.
    assign last_slot = (cnt_q != 7'd0) && (cnt_q == {1'b0, len_q} + 7'd1);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        gap_d      = gap_q;
        pkt_done_d = 1'b0;
        len_err_d  = 1'b0;
        addr_err_d = 1'b0;
        byte_take  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    owner_d = win_idx;
                    ptr_d   = ptr_nxt;
                    cnt_d   = 7'd0;
                    if (win_hdr[1:0] == 2'b11) begin
                        state_d    = S_DROP;
                        len_d      = win_hdr[7:2];
                        addr_err_d = 1'b1;
                    end else begin
                        state_d = S_XFER;
                    end
                end
            end
            S_XFER:  byte_take = !router_busy;
            S_DROP:  byte_take = 1'b1;
            S_GAP: begin
                if (gap_q != GW'(GAP_CYCLES - 1)) begin
                    gap_d = gap_q + GW'(1);
                end else if (!router_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (byte_take) begin
            if (cnt_q == 7'd0) begin
                cnt_d = 7'd1;
                if (state_q == S_XFER) begin
                    len_d = own_data[7:2];
                end
            end else if (last_slot || !own_valid) begin
                // Parity slot reached, or the source ended early: either way this byte closes the packet.
                pkt_done_d = 1'b1;
                len_err_d  = (last_slot && own_valid) || (!last_slot && !own_valid);
                state_d    = S_GAP;
                gap_d      = '0;
                cnt_d      = 7'd0;
            end else begin
                cnt_d = cnt_q + 7'd1;
            end
        end
    end

    // Handshake: source g's byte moves on a rising edge where src_busy[g]==0; otherwise it holds.
    always_comb begin
        src_busy      = '1;
        grant         = '0;
        rtr_data      = 8'd0;
        rtr_pkt_valid = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (owner_q == PW'(i)) begin
                if (state_q == S_XFER) begin
                    src_busy[i] = router_busy;
                    grant[i]    = 1'b1;
                end else if (state_q == S_DROP) begin
                    src_busy[i] = 1'b0;
                    grant[i]    = 1'b1;
                end
            end
        end
        if (state_q == S_XFER) begin
            rtr_data      = own_data;
            rtr_pkt_valid = own_valid && !last_slot;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= 7'd0;
            len_q      <= 6'd0;
            gap_q      <= '0;
            pkt_done_q <= 1'b0;
            len_err_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            gap_q      <= gap_d;
            pkt_done_q <= pkt_done_d;
            len_err_q  <= len_err_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign pkt_done  = pkt_done_q;
    assign len_err   = len_err_q;
    assign addr_err  = addr_err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_router_src_arbiter.sv
// Bench for router_src_arbiter: sources replay byte streams, a packet-level model predicts every cycle.
module tb_router_src_arbiter;

    localparam int N   = 3;
    localparam int GAP = 2;

    logic           clock = 1'b0;
    logic           resetn;
    logic [N-1:0]   src_pkt_valid;
    logic [8*N-1:0] src_data;
    logic [N-1:0]   src_busy;
    logic           router_busy;
    logic           rtr_pkt_valid;
    logic [7:0]     rtr_data;
    logic [N-1:0]   grant;
    logic           pkt_done;
    logic           len_err;
    logic           addr_err;
    logic [1:0]     state_dbg;

    always #5 clock = ~clock;

    router_src_arbiter #(.NUM_SRC(N), .GAP_CYCLES(GAP)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .src_pkt_valid (src_pkt_valid),
        .src_data      (src_data),
        .src_busy      (src_busy),
        .router_busy   (router_busy),
        .rtr_pkt_valid (rtr_pkt_valid),
        .rtr_data      (rtr_data),
        .grant         (grant),
        .pkt_done      (pkt_done),
        .len_err       (len_err),
        .addr_err      (addr_err),
        .state_dbg     (state_dbg)
    );

    int total = 0;
    int bad   = 0;

    // Per-source byte stream, each entry {pkt_valid, data}.
    logic [8:0] sq [N][$];
    int         cur_len   [N];
    int         cur_pay   [N];
    int         pkts_left [N];
    bit         busy_q [$];

    bit gen_en, busy_en, chk_en, rst_req;

    // Packet-level reference state.
    int         mptr, owner, k_len, taken, gap_k;
    bit         model_idle, drop, perr;
    logic [N-1:0] nx_grant;
    bit         nx_done, nx_lerr, nx_aerr;
    int         pkts_seen = 0;
    int         done_obs  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int start);
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic load(input int s, input logic [7:0] hdr, input int pay);
        sq[s].delete();
        sq[s].push_back({1'b1, hdr});
        for (int i = 0; i < pay; i++) sq[s].push_back({1'b1, 8'($urandom_range(0, 255))});
        sq[s].push_back({1'b0, 8'($urandom_range(0, 255))});
        cur_len[s] = int'(hdr[7:2]);
        cur_pay[s] = pay;
    endtask

    task automatic gen_random(input int s);
        int len;
        int addr;
        int pay;
        len  = $urandom_range(0, 5);
        addr = $urandom_range(0, 3);
        pay  = ($urandom_range(0, 3) != 0) ? len : $urandom_range(0, len + 2);
        load(s, {6'(len), 2'(addr)}, pay);
        pkts_left[s]--;
    endtask

    task automatic model_reset();
        for (int s = 0; s < N; s++) sq[s].delete();
        mptr       = 0;
        owner      = -1;
        model_idle = 1'b1;
        taken      = 0;
        gap_k      = 0;
        nx_grant   = '0;
        nx_done    = 1'b0;
        nx_lerr    = 1'b0;
        nx_aerr    = 1'b0;
    endtask

    task automatic tick();
        logic [N-1:0] exp_busy;
        logic [N-1:0] req;
        logic [7:0]   hdr;
        bit           acc;
        int           own_now;
        int           w;
        own_now = -1;
        @(negedge clock);
        resetn = !rst_req;
        for (int s = 0; s < N; s++) begin
            if (gen_en && sq[s].size() == 0 && pkts_left[s] > 0 && $urandom_range(0, 1) == 1)
                gen_random(s);
            if (sq[s].size() > 0) begin
                src_pkt_valid[s]    = sq[s][0][8];
                src_data[8*s +: 8]  = sq[s][0][7:0];
            end else begin
                src_pkt_valid[s]    = 1'b0;
                src_data[8*s +: 8]  = 8'h00;
            end
        end
        if (busy_q.size() > 0) router_busy = busy_q.pop_front();
        else router_busy = busy_en ? ($urandom_range(0, 2) == 0) : 1'b0;
        #1;
        if (chk_en) begin
            check_eq("grant", grant, nx_grant);
            check_eq("pkt_done", pkt_done, nx_done);
            check_eq("len_err", len_err, nx_lerr);
            check_eq("addr_err", addr_err, nx_aerr);
            if (pkt_done === 1'b1) done_obs++;
            req      = src_pkt_valid;
            exp_busy = '1;
            own_now  = owner;
            nx_done  = 1'b0;
            nx_lerr  = 1'b0;
            nx_aerr  = 1'b0;
            if (owner >= 0) begin
                acc = drop || !router_busy;
                exp_busy[owner] = !acc;
                check_eq("src_busy", src_busy, exp_busy);
                if (drop) begin
                    check_eq("drop_rtr_valid", rtr_pkt_valid, 0);
                    check_eq("drop_rtr_data", rtr_data, 0);
                end else if (sq[owner].size() > 0) begin
                    check_eq("rtr_data", rtr_data, sq[owner][0][7:0]);
                    check_eq("rtr_pkt_valid", rtr_pkt_valid, taken < k_len - 1);
                end else begin
                    check_eq("src_stream_left", sq[owner].size(), k_len - taken);
                end
                nx_grant = N'(1) << owner;
                if (acc) begin
                    taken++;
                    if (taken == k_len) begin
                        nx_grant   = '0;
                        nx_done    = 1'b1;
                        nx_lerr    = perr;
                        owner      = -1;
                        model_idle = 1'b0;
                        gap_k      = 0;
                        pkts_seen++;
                    end
                end
            end else begin
                check_eq("idle_src_busy", src_busy, exp_busy);
                check_eq("idle_rtr_valid", rtr_pkt_valid, 0);
                check_eq("idle_rtr_data", rtr_data, 0);
                nx_grant = '0;
                if (model_idle) begin
                    if (req != '0) begin
                        w          = rr_pick(req, mptr);
                        owner      = w;
                        mptr       = (w + 1) % N;
                        hdr        = sq[w][0][7:0];
                        drop       = (hdr[1:0] == 2'b11);
                        k_len      = ((cur_pay[w] < cur_len[w]) ? cur_pay[w] : cur_len[w]) + 2;
                        perr       = (cur_pay[w] != cur_len[w]);
                        taken      = 0;
                        nx_grant   = N'(1) << w;
                        nx_aerr    = drop;
                        model_idle = 1'b0;
                    end
                end else begin
                    if (gap_k >= GAP - 1 && !router_busy) model_idle = 1'b1;
                    gap_k++;
                end
            end
        end
        for (int s = 0; s < N; s++) begin
            if (src_busy[s] === 1'b0 && sq[s].size() > 0) void'(sq[s].pop_front());
        end
        // A finished packet releases its source; any bytes it still meant to send are abandoned.
        if (own_now >= 0 && owner < 0) sq[own_now].delete();
    endtask

    task automatic run_quiet(input int limit);
        int n;
        bit quiet;
        n     = 0;
        quiet = 1'b0;
        while (!quiet && n < limit) begin
            tick();
            n++;
            quiet = (owner < 0) && model_idle;
            for (int s = 0; s < N; s++) begin
                if (sq[s].size() != 0) quiet = 1'b0;
                if (gen_en && pkts_left[s] != 0) quiet = 1'b0;
            end
        end
        check_eq("quiet_reached", quiet, 1);
    endtask

    initial begin
        int  n;
        bit  reached;
        src_pkt_valid = '0;
        src_data      = '0;
        router_busy   = 1'b0;
        resetn        = 1'b0;
        gen_en        = 1'b0;
        busy_en       = 1'b0;
        chk_en        = 1'b0;
        rst_req       = 1'b1;
        for (int s = 0; s < N; s++) pkts_left[s] = 0;
        model_reset();

        // Reset state.
        tick();
        chk_en = 1'b1;
        tick();
        rst_req = 1'b0;

        // Single packet from source 1: header 0x0A (addr 2, len 2).
        load(1, 8'h0A, 2);
        run_quiet(60);

        // Router stalls for three cycles after the first payload byte.
        busy_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        load(1, 8'h0A, 2);
        run_quiet(60);

        // Fresh pointer, all three sources request len-1 packets together.
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        model_reset();
        for (int s = 0; s < N; s++) load(s, 8'h05, 1);
        run_quiet(120);

        // Illegal address: drained, never forwarded.
        load(0, 8'h0F, 3);
        run_quiet(60);

        // Early end: len 4 announced, only 2 payload bytes sent.
        load(2, 8'h10, 2);
        run_quiet(60);

        // Late end: len 1 announced, 3 payload bytes sent.
        load(1, 8'h06, 3);
        run_quiet(60);

        // Randomized traffic with random router back-pressure.
        for (int s = 0; s < N; s++) pkts_left[s] = 30;
        gen_en  = 1'b1;
        busy_en = 1'b1;
        run_quiet(8000);
        gen_en  = 1'b0;
        busy_en = 1'b0;

        // Reset in the middle of a transfer, then sources 0 and 2 request together.
        load(1, 8'h29, 10);
        n = 0;
        reached = 1'b0;
        while (!reached && n < 40) begin
            tick();
            n++;
            reached = (owner == 1) && (taken >= 3);
        end
        check_eq("midxfer_reached", reached, 1);
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        model_reset();
        load(0, 8'h04, 1);
        load(2, 8'h06, 1);
        run_quiet(80);

        check_eq("pkt_done_count", done_obs, pkts_seen);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
